// File: rtl/uart_pkt_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkt_pkg
// Shared definitions for the UART packet controller slice.
//   SYNC_BYTE   : byte value that opens every packet (0xA5)
//   pkt_state_t : packet framing states (IDLE, LEN, PAYLOAD, CHK, HOLD)
//   lenWidth()  : width needed to hold a payload length of 0..maxPayload
// ---------------------------------------------------------------------------
package uart_pkt_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CHK,
    HOLD
  } pkt_state_t;

  // Length field must represent MAX_PAYLOAD itself, hence the +1.
  function automatic int lenWidth(input int maxPayload);
    return $clog2(maxPayload + 1);
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// ---------------------------------------------------------------------------
// uart_pkt_buf
// DEPTH x 8 payload storage, one write port and one registered read port.
// Ports:
//   clk, rstn          : clock, asynchronous active-low reset
//   i_wrEn/i_wrAddr/i_wrData : synchronous write port
//   i_rdAddr           : read address
//   o_rdData           : read data, valid one cycle after i_rdAddr
// The storage array itself is never reset; only the read register is, so
// the read data output comes up as zero.
// ---------------------------------------------------------------------------
module uart_pkt_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_wrEn,
  input  logic [AW-1:0] i_wrAddr,
  input  logic [7:0]    i_wrData,
  input  logic [AW-1:0] i_rdAddr,
  output logic [7:0]    o_rdData
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdData;

  // Plain storage write; no reset so this maps onto RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  // Registered read, cleared by reset so the output has a defined value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdData <= 8'h00;
    end else begin
      r_rdData <= r_mem[i_rdAddr];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_pkt_ctrl
// Frames UART receiver byte strobes into SYNC, LEN, payload[, CHK] packets,
// enforces an inter-byte timeout, buffers the payload and offers it to the
// host with a valid/ready handshake.
// Configuration macro: UART_PKT_CHK_EN
//   defined   : frame ends with an XOR checksum byte (LEN ^ payload bytes)
//   undefined : no checksum byte, last payload byte completes the packet,
//               err_chk is tied low
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   rx_data, rx_valid    : byte and one-cycle strobe from the UART receiver
//   pkt_valid, pkt_ready : packet handshake with the host
//   pkt_len              : payload length of the held packet
//   rd_addr, rd_data     : payload buffer read port (1 cycle latency)
//   busy                 : controller is not in IDLE
//   err_len, err_chk, err_timeout : one-cycle error pulses
//   drop_cnt             : saturating count of bytes dropped while holding
// ---------------------------------------------------------------------------
module uart_rx_pkt_ctrl
  import uart_pkt_pkg::*;
#(
  parameter  int CLK_RATE     = 50000000,
  parameter  int BAUD_RATE    = 115200,
  parameter  int MAX_PAYLOAD  = 16,
  parameter  int TIMEOUT_BITS = 20,
  localparam int LW           = lenWidth(MAX_PAYLOAD),
  localparam int AW           = $clog2(MAX_PAYLOAD)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          pkt_valid,
  input  logic          pkt_ready,
  output logic [LW-1:0] pkt_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          busy,
  output logic          err_len,
  output logic          err_chk,
  output logic          err_timeout,
  output logic [7:0]    drop_cnt
);

  localparam int CLOCKS_PER_BIT = CLK_RATE / BAUD_RATE;
  localparam int TIMEOUT_CYC    = TIMEOUT_BITS * CLOCKS_PER_BIT;
  localparam int TW             = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    MAX_LEN = 8'(MAX_PAYLOAD);

  pkt_state_t    r_state;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_idx;
  logic [7:0]    r_dropCnt;
  logic [TW-1:0] r_toCnt;
  logic          r_pktValid;
  logic          r_busy;
  logic          r_errLen;
  logic          r_errTimeout;
  logic          w_parsing;
  logic          w_timeout;
  logic          w_wrEn;
`ifdef UART_PKT_CHK_EN
  logic [7:0]    r_xor;
  logic          r_errChk;
`endif

  // A strobe in the timeout cycle takes priority, so the timeout only fires
  // on a quiet cycle.
  assign w_parsing = (r_state == LEN) || (r_state == PAYLOAD) || (r_state == CHK);
  assign w_timeout = w_parsing && !rx_valid && (r_toCnt == TO_LAST);
  assign w_wrEn    = (r_state == PAYLOAD) && rx_valid;

  // Inter-byte timer: runs only while a packet is being parsed and restarts
  // on every received byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_toCnt <= '0;
    end else if (rx_valid || !w_parsing || w_timeout) begin
      r_toCnt <= '0;
    end else begin
      r_toCnt <= r_toCnt + TW'(1);
    end
  end

  // Packet framing FSM. Status outputs (busy, pkt_valid, error pulses) are
  // registered alongside each state change so they line up with the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_idx        <= '0;
      r_dropCnt    <= 8'h00;
      r_pktValid   <= 1'b0;
      r_busy       <= 1'b0;
      r_errLen     <= 1'b0;
      r_errTimeout <= 1'b0;
`ifdef UART_PKT_CHK_EN
      r_xor        <= 8'h00;
      r_errChk     <= 1'b0;
`endif
    end else begin
      r_errLen     <= 1'b0;
      r_errTimeout <= 1'b0;
`ifdef UART_PKT_CHK_EN
      r_errChk     <= 1'b0;
`endif
      if (w_timeout) begin
        r_state      <= IDLE;
        r_busy       <= 1'b0;
        r_errTimeout <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
              r_state <= LEN;
              r_busy  <= 1'b1;
            end
          end
          LEN: begin
            if (rx_valid) begin
              if ((rx_data != 8'h00) && (rx_data <= MAX_LEN)) begin
                r_len   <= rx_data[LW-1:0];
                r_idx   <= '0;
`ifdef UART_PKT_CHK_EN
                r_xor   <= rx_data;
`endif
                r_state <= PAYLOAD;
              end else begin
                r_errLen <= 1'b1;
                r_state  <= IDLE;
                r_busy   <= 1'b0;
              end
            end
          end
          PAYLOAD: begin
            if (rx_valid) begin
              r_idx <= r_idx + LW'(1);
`ifdef UART_PKT_CHK_EN
              r_xor <= r_xor ^ rx_data;
`endif
              if ((r_idx + LW'(1)) == r_len) begin
`ifdef UART_PKT_CHK_EN
                r_state <= CHK;
`else
                r_state    <= HOLD;
                r_pktValid <= 1'b1;
`endif
              end
            end
          end
`ifdef UART_PKT_CHK_EN
          CHK: begin
            if (rx_valid) begin
              if (rx_data == r_xor) begin
                r_state    <= HOLD;
                r_pktValid <= 1'b1;
              end else begin
                r_errChk <= 1'b1;
                r_state  <= IDLE;
                r_busy   <= 1'b0;
              end
            end
          end
`endif
          HOLD: begin
            // Bytes arriving while a packet is held are discarded, including
            // one that coincides with the completing handshake.
            if (rx_valid && (r_dropCnt != 8'hFF)) begin
              r_dropCnt <= r_dropCnt + 8'd1;
            end
            if (pkt_ready) begin
              r_state    <= IDLE;
              r_pktValid <= 1'b0;
              r_busy     <= 1'b0;
            end
          end
          default: begin
            r_state    <= IDLE;
            r_pktValid <= 1'b0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  uart_pkt_buf #(
    .DEPTH (MAX_PAYLOAD),
    .AW    (AW)
  ) u_buf (
    .clk      (clk),
    .rstn     (rstn),
    .i_wrEn   (w_wrEn),
    .i_wrAddr (r_idx[AW-1:0]),
    .i_wrData (rx_data),
    .i_rdAddr (rd_addr),
    .o_rdData (rd_data)
  );

  assign pkt_valid   = r_pktValid;
  assign pkt_len     = r_len;
  assign busy        = r_busy;
  assign err_len     = r_errLen;
  assign err_timeout = r_errTimeout;
  assign drop_cnt    = r_dropCnt;
`ifdef UART_PKT_CHK_EN
  assign err_chk     = r_errChk;
`else
  assign err_chk     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_pkt_ctrl
// Self-checking bench for uart_rx_pkt_ctrl at default parameters. Packets
// are built from their definition (good, bad length, bad checksum, noise)
// and the expected outcome follows from how each packet was constructed.
// Honours UART_PKT_CHK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_uart_rx_pkt_ctrl;

  localparam int MAX_PAYLOAD = 16;
  localparam int TIMEOUT_CYC = 20 * (50000000 / 115200);

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       pkt_ready = 1'b0;
  logic [3:0] rd_addr = 4'h0;
  logic       pkt_valid;
  logic [4:0] pkt_len;
  logic [7:0] rd_data;
  logic       busy;
  logic       err_len;
  logic       err_chk;
  logic       err_timeout;
  logic [7:0] drop_cnt;

  int nVectors = 0;
  int nMiss = 0;
  int obsLen = 0;
  int obsChk = 0;
  int obsTo = 0;
  int expLen = 0;
  int expChk = 0;
  int expTo = 0;
  int expDrop = 0;

  logic [7:0] frame[$];
  logic [7:0] expPayload[$];

  uart_rx_pkt_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_len     (pkt_len),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .err_len     (err_len),
    .err_chk     (err_chk),
    .err_timeout (err_timeout),
    .drop_cnt    (drop_cnt)
  );

  // 100 MHz-style free-running clock; absolute period is irrelevant here.
  always #5 clk = ~clk;

  // Count every error pulse so "exactly once" and "never" can be checked.
  always @(posedge clk) begin
    if (err_len) obsLen++;
    if (err_chk) obsChk++;
    if (err_timeout) obsTo++;
  end

  // Hard stop in case something stalls the stimulus sequence.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge: strobes one byte for exactly one cycle.
  task automatic applyStimulus(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic sendBytes(input int first, input int last, input int maxGap);
    for (int i = first; i <= last; i++) begin
      applyStimulus(frame[i]);
      if (i != last && maxGap > 0) idle($urandom_range(0, maxGap));
    end
  endtask

  task automatic bumpDrop();
    if (expDrop < 255) expDrop++;
  endtask

  // Builds a well-formed frame with a random payload of the given length.
  task automatic makeGood(input int len);
    logic [7:0] x;
    logic [7:0] b;
    frame = {};
    expPayload = {};
    frame.push_back(8'hA5);
    frame.push_back(8'(len));
    x = 8'(len);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      expPayload.push_back(b);
      frame.push_back(b);
      x = x ^ b;
    end
`ifdef UART_PKT_CHK_EN
    frame.push_back(x);
`endif
  endtask

  task automatic checkCounts();
    idle(2);
    checkOutput("err_len_count", 32'(obsLen), 32'(expLen));
    checkOutput("err_chk_count", 32'(obsChk), 32'(expChk));
    checkOutput("err_timeout_count", 32'(obsTo), 32'(expTo));
  endtask

  // Called one cycle after the final strobe of an accepted packet.
  task automatic expectPacket();
    checkOutput("pkt_valid_rise", 32'(pkt_valid), 32'd1);
    checkOutput("pkt_len", 32'(pkt_len), 32'(expPayload.size()));
    checkOutput("busy_hold", 32'(busy), 32'd1);
    for (int i = 0; i < expPayload.size(); i++) begin
      rd_addr = 4'(i);
      @(negedge clk);
      checkOutput("rd_data", 32'(rd_data), 32'(expPayload[i]));
    end
  endtask

  task automatic releasePacket(input bit withByte);
    pkt_ready = 1'b1;
    if (withByte) begin
      rx_data = 8'hA5;
      rx_valid = 1'b1;
      bumpDrop();
    end
    @(negedge clk);
    pkt_ready = 1'b0;
    rx_valid = 1'b0;
    checkOutput("pkt_valid_fall", 32'(pkt_valid), 32'd0);
    checkOutput("busy_after_release", 32'(busy), 32'd0);
    checkOutput("drop_cnt", 32'(drop_cnt), 32'(expDrop));
  endtask

  task automatic runGood(input int len, input int maxGap);
    int k;
    makeGood(len);
    sendBytes(0, frame.size() - 2, maxGap);
    checkOutput("pkt_valid_early", 32'(pkt_valid), 32'd0);
    if (maxGap > 0) idle($urandom_range(0, maxGap));
    applyStimulus(frame[frame.size() - 1]);
    expectPacket();
    k = $urandom_range(0, 3);
    for (int i = 0; i < k; i++) begin
      applyStimulus(8'($urandom_range(0, 255)));
      bumpDrop();
    end
    releasePacket(1'($urandom_range(0, 1)));
  endtask

  task automatic runBadLen(input logic [7:0] l, input int maxGap);
    frame = {8'hA5, l};
    sendBytes(0, 1, maxGap);
    expLen++;
    checkOutput("err_len_pulse", 32'(err_len), 32'd1);
    checkOutput("busy_after_err_len", 32'(busy), 32'd0);
    checkOutput("pkt_valid_err_len", 32'(pkt_valid), 32'd0);
  endtask

  // Main sequence: reset, directed cases, randomized packets, timeout,
  // drop saturation, then reset in the middle of a payload.
  initial begin
    int kind;
    int nNoise;
    logic [7:0] b;

    idle(2);
    checkOutput("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_err_len", 32'(err_len), 32'd0);
    checkOutput("rst_err_chk", 32'(err_chk), 32'd0);
    checkOutput("rst_err_timeout", 32'(err_timeout), 32'd0);
    checkOutput("rst_pkt_len", 32'(pkt_len), 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rstn = 1'b1;
    idle(2);

    pkt_ready = 1'b1;
    idle(1);
    pkt_ready = 1'b0;
    checkOutput("ready_in_idle", 32'(pkt_valid), 32'd0);

    frame = {8'h00, 8'hFF, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
`ifdef UART_PKT_CHK_EN
    frame.push_back(8'h03);
`endif
    expPayload = {8'h11, 8'h22, 8'h33};
    sendBytes(0, frame.size() - 2, 0);
    checkOutput("dir_pkt_valid_early", 32'(pkt_valid), 32'd0);
    applyStimulus(frame[frame.size() - 1]);
    expectPacket();
    releasePacket(1'b0);
    checkCounts();

`ifdef UART_PKT_CHK_EN
    frame = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
    sendBytes(0, 4, 0);
    expChk++;
    checkOutput("err_chk_pulse", 32'(err_chk), 32'd1);
    checkOutput("busy_after_err_chk", 32'(busy), 32'd0);
    idle(1);
    checkOutput("pkt_valid_bad_chk", 32'(pkt_valid), 32'd0);
    checkCounts();
    runGood(5, 0);
`endif

    runBadLen(8'h00, 0);
    runBadLen(8'h11, 0);
    checkCounts();

    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 3);
      nNoise = $urandom_range(0, 2);
      for (int n = 0; n < nNoise; n++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        applyStimulus(b);
      end
      case (kind)
        1: runBadLen(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_PAYLOAD + 1, 255)), 3);
        2: begin
`ifdef UART_PKT_CHK_EN
          makeGood($urandom_range(1, MAX_PAYLOAD));
          frame[frame.size() - 1] = frame[frame.size() - 1] ^ 8'($urandom_range(1, 255));
          sendBytes(0, frame.size() - 1, 3);
          expChk++;
          checkOutput("err_chk_pulse", 32'(err_chk), 32'd1);
          checkOutput("busy_after_err_chk", 32'(busy), 32'd0);
          checkOutput("pkt_valid_bad_chk", 32'(pkt_valid), 32'd0);
`else
          runGood($urandom_range(1, MAX_PAYLOAD), 3);
`endif
        end
        default: runGood($urandom_range(1, MAX_PAYLOAD), 3);
      endcase
      checkCounts();
    end

    frame = {8'hA5, 8'h04, 8'h01};
    sendBytes(0, 2, 0);
    idle(TIMEOUT_CYC - 1);
    checkOutput("timeout_not_yet", 32'(err_timeout), 32'd0);
    checkOutput("busy_before_timeout", 32'(busy), 32'd1);
    idle(1);
    expTo++;
    checkOutput("timeout_pulse", 32'(err_timeout), 32'd1);
    checkOutput("busy_after_timeout", 32'(busy), 32'd0);
    checkCounts();

    makeGood(4);
    sendBytes(0, 2, 0);
    idle(TIMEOUT_CYC - 1);
    applyStimulus(frame[3]);
    sendBytes(4, frame.size() - 1, 0);
    expectPacket();
    releasePacket(1'b0);
    checkCounts();

    makeGood(6);
    sendBytes(0, frame.size() - 1, 1);
    expectPacket();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(8'($urandom_range(0, 255)));
      bumpDrop();
    end
    checkOutput("drop_cnt_saturated", 32'(drop_cnt), 32'(expDrop));
    checkOutput("drop_cnt_is_255", 32'(drop_cnt), 32'd255);
    expectPacket();
    releasePacket(1'b0);
    checkCounts();

    makeGood(8);
    sendBytes(0, 4, 1);
    rd_addr = 4'h2;
    rstn = 1'b0;
    #1;
    expDrop = 0;
    checkOutput("midrst_pkt_valid", 32'(pkt_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_pkt_len", 32'(pkt_len), 32'd0);
    checkOutput("midrst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("midrst_drop_cnt", 32'(drop_cnt), 32'(expDrop));
    checkOutput("midrst_err_any", 32'({err_len, err_chk, err_timeout}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    checkCounts();
    runGood(8, 2);
    checkCounts();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule
